// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: op modes, FSM states, op config.
package usr_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ROT = 2'b01;
    localparam logic [1:0] MODE_ARI = 2'b10;
    localparam logic [1:0] MODE_SER = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Operation settings captured at start and held for the whole op
    typedef struct packed {
        logic [1:0] mode;
        logic       dir;
    } op_cfg_t;

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the universal shift register.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] din,
    input  logic [1:0]   mode,
    input  logic         dir,
    input  logic         w,
    output logic [N-1:0] nxt_c,
    output logic         so_c
);

    logic fill;

    // Pick the bit entering the vacated end, then shift one position
    always_comb begin
        nxt_c = din;
        so_c  = 1'b0;
        fill  = 1'b0;
        if (dir) begin
            so_c = din[N-1];
            case (mode)
                MODE_ROT: fill = din[N-1];
                MODE_SER: fill = w;
                default:  fill = 1'b0;
            endcase
            nxt_c = {din[N-2:0], fill};
        end else begin
            so_c = din[0];
            case (mode)
                MODE_ROT: fill = din[0];
                MODE_ARI: fill = din[N-1];
                MODE_SER: fill = w;
                default:  fill = 1'b0;
            endcase
            nxt_c = {fill, din[N-1:1]};
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, multi-step shifts with start/busy/done handshake.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned SHW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [N-1:0]   R,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic           dir,
    input  logic [SHW-1:0] amount,
    input  logic           w,
    output logic [N-1:0]   out,
    output logic           sout,
    output logic           busy,
    output logic           done
);

    state_t         state_q, state_nxt;
    op_cfg_t        op_q, op_nxt;
    logic [SHW-1:0] cnt_q, cnt_nxt;
    logic [N-1:0]   out_nxt;
    logic           sout_nxt;
    logic [N-1:0]   step_nxt;
    logic           step_so;

    usr_shift_step #(.N(N)) u_step (
        .din   (out),
        .mode  (op_q.mode),
        .dir   (op_q.dir),
        .w     (w),
        .nxt_c (step_nxt),
        .so_c  (step_so)
    );

    // State, op regs, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            out     <= '0;
            sout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            op_q    <= op_nxt;
            cnt_q   <= cnt_nxt;
            out     <= out_nxt;
            sout    <= sout_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
        end
    end

    // Next-state and datapath selection
    always_comb begin
        state_nxt = state_q;
        op_nxt    = op_q;
        cnt_nxt   = cnt_q;
        out_nxt   = out;
        sout_nxt  = sout;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    out_nxt = R;
                end else if (start) begin
                    op_nxt.mode = mode;
                    op_nxt.dir  = dir;
                    cnt_nxt     = amount;
                    state_nxt   = (amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                out_nxt  = step_nxt;
                sout_nxt = step_so;
                cnt_nxt  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
